// File: rtl/cache_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_arbiter_pkg
// Description : Shared types and constants for the cache read arbiter
//               (FSM state encoding, AXI ARID values, AXI ARSIZE for a word).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_rd_arbiter_pkg;

    // Arbiter FSM: idle / address phase / data phase
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    localparam logic [3:0] ARID_IC     = 4'd0;
    localparam logic [3:0] ARID_DC     = 4'd1;
    localparam logic [2:0] ARSIZE_WORD = 3'b010;

endpackage : cache_rd_arbiter_pkg
`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_arbiter
// Description : Shares one AXI AR/R channel pair between the iCache refill
//               port and the dCache refill/uncached port. One outstanding
//               transaction; R beats are steered back to the owner and the
//               bus is released on rlast. bus_err is a sticky protocol flag.
// Config      : CACHE_RD_RR_EN - defined: round-robin priority flipping to
//               the non-owner after each completed transaction; undefined:
//               fixed priority with the dCache always winning.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // iCache side
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_gnt,
    output logic              ic_ret_valid,
    output logic              ic_ret_last,
    // dCache side
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    input  logic              dc_rd_uc,
    output logic              dc_rd_gnt,
    output logic              dc_ret_valid,
    output logic              dc_ret_last,
    output logic [DATA_W-1:0] ret_data,
    // AXI AR channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    // AXI R channel
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // Status
    output logic              bus_err
);

    localparam int         CNT_W     = $clog2(LINE_BEATS) + 1;
    localparam logic [7:0] C_LINE_LEN = 8'(LINE_BEATS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner_dc;
    logic [3:0]          r_arid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [7:0]          r_arlen;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_bus_err;

    logic                w_any_req;
    logic                w_prio_dc;
    logic                w_sel_dc;
    logic                w_beat;
    logic                w_done;
    logic                w_exp_last;

`ifdef CACHE_RD_RR_EN
    logic                r_prio_dc;

    // Priority pointer moves to the non-owner each time a burst completes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prio_dc <= 1'b1;
        end else if (w_done) begin
            r_prio_dc <= ~r_owner_dc;
        end
    end

    assign w_prio_dc = r_prio_dc;
`else
    assign w_prio_dc = 1'b1;
`endif

    assign w_any_req  = ic_rd_req | dc_rd_req;
    assign w_sel_dc   = dc_rd_req & (~ic_rd_req | w_prio_dc);
    assign w_beat     = (r_state == R) & rvalid;
    assign w_done     = w_beat & rlast;
    // The beat being accepted is the last expected one when the count of
    // beats already seen equals arlen
    assign w_exp_last = (8'(r_beat_cnt) == r_arlen);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one transaction at a time, no re-arbitration on rlast
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = AR;
            AR:      if (arready)   w_state_nxt = R;
            R:       if (rlast & rvalid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch owner and AR fields when leaving IDLE; held stable through AR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner_dc <= 1'b0;
            r_arid     <= ARID_IC;
            r_araddr   <= '0;
            r_arlen    <= '0;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_owner_dc <= w_sel_dc;
            r_arid     <= w_sel_dc ? ARID_DC : ARID_IC;
            r_araddr   <= w_sel_dc ? dc_rd_addr : ic_rd_addr;
            r_arlen    <= (w_sel_dc && dc_rd_uc) ? 8'd0 : C_LINE_LEN;
        end
    end

    // Beat counter: clears on rlast, saturates on over-long bursts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beat_cnt <= '0;
        end else if (w_done) begin
            r_beat_cnt <= '0;
        end else if (w_beat && (r_beat_cnt != {CNT_W{1'b1}})) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Sticky protocol error: rlast misplaced or response ID not the owner's
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus_err <= 1'b0;
        end else if (w_beat && ((rlast != w_exp_last) || (rid != r_arid))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign arvalid      = (r_state == AR);
    assign arid         = r_arid;
    assign araddr       = r_araddr;
    assign arlen        = r_arlen;
    assign arsize       = ARSIZE_WORD;
    assign rready       = (r_state == R);

    assign ic_rd_gnt    = arvalid & arready & ~r_owner_dc;
    assign dc_rd_gnt    = arvalid & arready &  r_owner_dc;
    assign ic_ret_valid = w_beat & ~r_owner_dc;
    assign dc_ret_valid = w_beat &  r_owner_dc;
    assign ic_ret_last  = w_done & ~r_owner_dc;
    assign dc_ret_last  = w_done &  r_owner_dc;
    assign ret_data     = rdata;
    assign bus_err      = r_bus_err;

endmodule : cache_rd_arbiter
`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_rd_arbiter
// Description : Directed self-checking bench for cache_rd_arbiter. Expected
//               owner order depends on CACHE_RD_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ic_rd_req = 1'b0;
    logic [31:0] ic_rd_addr = '0;
    logic        ic_rd_gnt, ic_ret_valid, ic_ret_last;
    logic        dc_rd_req = 1'b0;
    logic [31:0] dc_rd_addr = '0;
    logic        dc_rd_uc = 1'b0;
    logic        dc_rd_gnt, dc_ret_valid, dc_ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        bus_err;

    int vectors     = 0;
    int miscompares = 0;

    cache_rd_arbiter #(.LINE_BEATS(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_gnt(ic_rd_gnt),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_uc(dc_rd_uc),
        .dc_rd_gnt(dc_rd_gnt), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"},  32'(rready),  32'd0);
        chk({tag, "_ic_gnt"},  32'(ic_rd_gnt), 32'd0);
        chk({tag, "_dc_gnt"},  32'(dc_rd_gnt), 32'd0);
        chk({tag, "_ic_val"},  32'(ic_ret_valid), 32'd0);
        chk({tag, "_dc_val"},  32'(dc_ret_valid), 32'd0);
    endtask

    // Address phase: stall cycles with arready low, then one accept cycle
    task automatic ar_phase(input bit exp_dc, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len, input int stall);
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            arready = (s == stall);
            #1;
            chk("ar_arvalid", 32'(arvalid), 32'd1);
            chk("ar_araddr",  araddr, exp_addr);
            chk("ar_arlen",   32'(arlen), 32'(exp_len));
            chk("ar_arid",    32'(arid), exp_dc ? 32'd1 : 32'd0);
            chk("ar_arsize",  32'(arsize), 32'd2);
            chk("ar_rready",  32'(rready), 32'd0);
            chk("ar_ic_gnt",  32'(ic_rd_gnt), 32'((s == stall) && !exp_dc));
            chk("ar_dc_gnt",  32'(dc_rd_gnt), 32'((s == stall) && exp_dc));
        end
    endtask

    // Data phase: n beats, rlast on beat index last_at, then one idle cycle
    task automatic burst(input bit own_dc, input int n, input logic [3:0] id, input int last_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            arready = 1'b0;
            rvalid  = 1'b1;
            rid     = id;
            rdata   = 32'hC0DE_0000 + 32'(i) + (own_dc ? 32'h100 : 32'h0);
            rlast   = (i == last_at);
            #1;
            chk("r_rready",   32'(rready), 32'd1);
            chk("r_own_val",  32'(own_dc ? dc_ret_valid : ic_ret_valid), 32'd1);
            chk("r_own_last", 32'(own_dc ? dc_ret_last : ic_ret_last), 32'(i == last_at));
            chk("r_oth_val",  32'(own_dc ? ic_ret_valid : dc_ret_valid), 32'd0);
            chk("r_oth_last", 32'(own_dc ? ic_ret_last : dc_ret_last), 32'd0);
            chk("r_data",     ret_data, 32'hC0DE_0000 + 32'(i) + (own_dc ? 32'h100 : 32'h0));
        end
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
        #1;
        chk("post_rready",  32'(rready), 32'd0);
        chk("post_arvalid", 32'(arvalid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_idle_outputs("rst");
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    bit exp_own [5];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // 1: iCache line refill, gnt one cycle after req
        @(negedge clk);
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1FC0_0000;
        #1;
        chk("t1_gnt_same_cycle", 32'(ic_rd_gnt), 32'd0);
        chk("t1_arvalid_early",  32'(arvalid), 32'd0);
        ar_phase(1'b0, 32'h1FC0_0000, 8'd7, 0);
        ic_rd_req = 1'b0;
        burst(1'b0, 8, 4'd0, 7);
        chk("t1_bus_err", 32'(bus_err), 32'd0);

        // 2: simultaneous requests, D first, I one idle cycle after D rlast
        @(negedge clk);
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1FC0_0040;
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h8000_1000;
        dc_rd_uc   = 1'b0;
        ar_phase(1'b1, 32'h8000_1000, 8'd7, 0);
        dc_rd_req = 1'b0;
        burst(1'b1, 8, 4'd1, 7);
        ar_phase(1'b0, 32'h1FC0_0040, 8'd7, 0);
        ic_rd_req = 1'b0;
        burst(1'b0, 8, 4'd0, 7);

        // 3: uncached single-beat dCache read
        @(negedge clk);
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'hBFAF_8000;
        dc_rd_uc   = 1'b1;
        ar_phase(1'b1, 32'hBFAF_8000, 8'd0, 0);
        dc_rd_req = 1'b0;
        dc_rd_uc  = 1'b0;
        burst(1'b1, 1, 4'd1, 0);
        chk("t3_bus_err", 32'(bus_err), 32'd0);

        // 4: arready stalled five cycles
        @(negedge clk);
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1FC0_0100;
        ar_phase(1'b0, 32'h1FC0_0100, 8'd7, 5);
        ic_rd_req = 1'b0;
        burst(1'b0, 8, 4'd0, 7);
        chk("t4_bus_err", 32'(bus_err), 32'd0);

        // 5a: early rlast on beat 5 of a cached D burst
        @(negedge clk);
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h8000_2000;
        ar_phase(1'b1, 32'h8000_2000, 8'd7, 0);
        dc_rd_req = 1'b0;
        burst(1'b1, 5, 4'd1, 4);
        chk("t5_early_last_err", 32'(bus_err), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_err_sticky", 32'(bus_err), 32'd1);
        chk("t5_idle_arvalid", 32'(arvalid), 32'd0);
        do_reset();

        // 5b: wrong rid during D burst
        @(negedge clk);
        #1;
        chk("t5b_err_clear", 32'(bus_err), 32'd0);
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h8000_3000;
        ar_phase(1'b1, 32'h8000_3000, 8'd7, 0);
        dc_rd_req = 1'b0;
        burst(1'b1, 8, 4'd0, 7);
        chk("t5_rid_err", 32'(bus_err), 32'd1);

        // 6a: reset asserted mid-burst
        do_reset();
        @(negedge clk);
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1FC0_0180;
        ar_phase(1'b0, 32'h1FC0_0180, 8'd7, 0);
        ic_rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            arready = 1'b0;
            rvalid  = 1'b1;
            rid     = 4'd0;
            rdata   = 32'h5A5A_0000 + 32'(i);
            rlast   = 1'b0;
            #1;
            chk("t6_mid_val", 32'(ic_ret_valid), 32'd1);
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_idle_outputs("t6_midrst");
        chk("t6_midrst_last", 32'(ic_ret_last), 32'd0);
        chk("t6_midrst_err",  32'(bus_err), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        resetn = 1'b1;

        // 6b: both requests held across five transactions
`ifdef CACHE_RD_RR_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk);
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1FC0_0200;
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h8000_4000;
        for (int t = 0; t < 5; t++) begin
            ar_phase(exp_own[t], exp_own[t] ? 32'h8000_4000 : 32'h1FC0_0200, 8'd7, 0);
            burst(exp_own[t], 8, exp_own[t] ? 4'd1 : 4'd0, 7);
        end
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
        chk("t6_bus_err", 32'(bus_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cache_rd_arbiter
`default_nettype wire
